// File: rtl/apb_slave_regs_if.sv
// APB bus bundle for apb_slave_regs: the requester drives address, control and
// write data; the register block returns read data, ready and error.
interface apb_slave_regs_if;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PSELx;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PADDR, PWRITE, PWDATA, PSELx, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWRITE, PWDATA, PSELx, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_regs.sv
// APB register slave: REG0-REG5 read/write, WCNT write counter and a fixed ID word.
// Define APB_SLAVE_ERR_EN to report illegal accesses on PSLVERR.
module apb_slave_regs #(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic            i_clk,
    input logic            i_reset_n,
    apb_slave_regs_if.slave apb
);
    localparam logic [31:0] ID_VALUE = 32'hA5B0_0001;
    localparam logic [3:0]  WAIT_LD  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t      state      = ST_IDLE;
    logic [3:0]  wait_cnt   = '0;
    logic [31:0] addr_q     = '0;
    logic        write_q    = 1'b0;
    logic [31:0] wdata_q    = '0;
    logic [31:0] regs [6]   = '{default: '0};
    logic [31:0] wcnt       = '0;
    logic [31:0] prdata_q   = '0;
    logic        pready_q   = 1'b0;
    logic        pslverr_q  = 1'b0;

    logic [31:0] dec_addr;
    logic        dec_write;
    logic [31:0] offset;
    logic [2:0]  idx;
    logic        acc_err;
    logic [31:0] rd_val;
    logic [31:0] nx_rdata;
    logic        nx_err;

    // In IDLE the decode looks at the live bus so a zero-wait access can
    // complete on its setup edge; afterwards the captured request is used.
    always_comb begin
        dec_addr  = (state == ST_IDLE) ? apb.PADDR  : addr_q;
        dec_write = (state == ST_IDLE) ? apb.PWRITE : write_q;
        offset    = dec_addr - BASE_ADDR;
        idx       = offset[4:2];
        acc_err   = (offset >= 32'd32) || (dec_addr[1:0] != 2'b00) ||
                    (dec_write && (idx >= 3'd6));
        case (idx)
            3'd6:    rd_val = wcnt;
            3'd7:    rd_val = ID_VALUE;
            default: rd_val = regs[idx];
        endcase
        nx_rdata = (!dec_write && !acc_err) ? rd_val : '0;
`ifdef APB_SLAVE_ERR_EN
        nx_err   = acc_err;
`else
        nx_err   = 1'b0;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            wcnt      <= '0;
            for (int unsigned i = 0; i < 6; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (apb.PSELx && !apb.PENABLE) begin
                        addr_q   <= apb.PADDR;
                        write_q  <= apb.PWRITE;
                        wdata_q  <= apb.PWDATA;
                        wait_cnt <= WAIT_LD;
                        if (WAIT_CYCLES == 0) begin
                            state     <= ST_DONE;
                            pready_q  <= 1'b1;
                            prdata_q  <= nx_rdata;
                            pslverr_q <= nx_err;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!apb.PSELx) begin
                        state <= ST_IDLE;
                    end else if (apb.PENABLE) begin
                        wait_cnt <= wait_cnt - 4'd1;
                        if (wait_cnt == 4'd1) begin
                            state     <= ST_DONE;
                            pready_q  <= 1'b1;
                            prdata_q  <= nx_rdata;
                            pslverr_q <= nx_err;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                    if (apb.PSELx && write_q && !acc_err) begin
                        regs[idx] <= wdata_q;
                        wcnt      <= wcnt + 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
endmodule
